// File: rtl/operand_stage.sv
// Operand stage: resolves source operands with EX/MEM and WB bypass,
// stalls on RAW/load-use hazards and registers the result with valid/ready.
module operand_stage #(
    parameter int ADDR_NBW = 5,
    parameter int DATA_NBW = 32
) (
    input  logic                clk,
    input  logic                rst_async_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [ADDR_NBW-1:0] i_rs1_addr,
    input  logic [ADDR_NBW-1:0] i_rs2_addr,
    input  logic [ADDR_NBW-1:0] i_rd_addr,
    input  logic                i_rd_wr_en,
    input  logic                i_is_load,
    output logic [ADDR_NBW-1:0] o_rf_addr_1,
    output logic [ADDR_NBW-1:0] o_rf_addr_2,
    input  logic [DATA_NBW-1:0] i_rf_dt_1,
    input  logic [DATA_NBW-1:0] i_rf_dt_2,
    input  logic                i_exm_wr_en,
    input  logic                i_exm_is_load,
    input  logic [ADDR_NBW-1:0] i_exm_addr,
    input  logic [DATA_NBW-1:0] i_exm_dt,
    input  logic                i_wb_wr_en,
    input  logic [ADDR_NBW-1:0] i_wb_addr,
    input  logic [DATA_NBW-1:0] i_wb_dt,
    input  logic                i_flush,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_NBW-1:0] o_rs1_dt,
    output logic [DATA_NBW-1:0] o_rs2_dt,
    output logic [ADDR_NBW-1:0] o_rd_addr,
    output logic                o_rd_wr_en,
    output logic                o_is_load
);

    logic                r_valid;
    logic [DATA_NBW-1:0] r_rs1_dt;
    logic [DATA_NBW-1:0] r_rs2_dt;
    logic [ADDR_NBW-1:0] r_rd_addr;
    logic                r_rd_wr_en;
    logic                r_is_load;

    logic                w_rs1_nz;
    logic                w_rs2_nz;
    logic [DATA_NBW-1:0] w_rs1_dt;
    logic [DATA_NBW-1:0] w_rs2_dt;
    logic                w_exm_fwd;
    logic                w_held_wr;
    logic                w_exm_ld;
    logic                w_hazard;
    logic                w_capture;

    assign o_rf_addr_1 = i_rs1_addr;
    assign o_rf_addr_2 = i_rs2_addr;

    assign w_rs1_nz  = (i_rs1_addr != '0);
    assign w_rs2_nz  = (i_rs2_addr != '0);
    // A load in EX/MEM has no data yet, so it never bypasses.
    assign w_exm_fwd = i_exm_wr_en && !i_exm_is_load;
    assign w_held_wr = r_valid && r_rd_wr_en;
    assign w_exm_ld  = i_exm_wr_en && i_exm_is_load;

    // rs1 bypass mux: x0, then EX/MEM, then WB, then register file
    always_comb begin
        w_rs1_dt = i_rf_dt_1;
        if (!w_rs1_nz)
            w_rs1_dt = '0;
        else if (w_exm_fwd && i_exm_addr == i_rs1_addr)
            w_rs1_dt = i_exm_dt;
        else if (i_wb_wr_en && i_wb_addr == i_rs1_addr)
            w_rs1_dt = i_wb_dt;
    end

    // rs2 bypass mux with the same priority as rs1
    always_comb begin
        w_rs2_dt = i_rf_dt_2;
        if (!w_rs2_nz)
            w_rs2_dt = '0;
        else if (w_exm_fwd && i_exm_addr == i_rs2_addr)
            w_rs2_dt = i_exm_dt;
        else if (i_wb_wr_en && i_wb_addr == i_rs2_addr)
            w_rs2_dt = i_wb_dt;
    end

    // Stall when a source depends on the held producer or an EX/MEM load
    always_comb begin
        w_hazard = 1'b0;
        if (i_valid) begin
            if (w_rs1_nz && w_held_wr && i_rs1_addr == r_rd_addr)
                w_hazard = 1'b1;
            if (w_rs2_nz && w_held_wr && i_rs2_addr == r_rd_addr)
                w_hazard = 1'b1;
            if (w_rs1_nz && w_exm_ld && i_rs1_addr == i_exm_addr)
                w_hazard = 1'b1;
            if (w_rs2_nz && w_exm_ld && i_rs2_addr == i_exm_addr)
                w_hazard = 1'b1;
        end
    end

    assign o_ready   = (!r_valid || i_ready) && !w_hazard && !i_flush;
    assign w_capture = i_valid && o_ready;

    // Output register: flush beats capture, capture beats drain, else hold
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_valid    <= 1'b0;
            r_rs1_dt   <= '0;
            r_rs2_dt   <= '0;
            r_rd_addr  <= '0;
            r_rd_wr_en <= 1'b0;
            r_is_load  <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid    <= 1'b1;
            r_rs1_dt   <= w_rs1_dt;
            r_rs2_dt   <= w_rs2_dt;
            r_rd_addr  <= i_rd_addr;
            r_rd_wr_en <= i_rd_wr_en;
            r_is_load  <= i_is_load;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_rs1_dt   = r_rs1_dt;
    assign o_rs2_dt   = r_rs2_dt;
    assign o_rd_addr  = r_rd_addr;
    assign o_rd_wr_en = r_rd_wr_en;
    assign o_is_load  = r_is_load;

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have parameters ADDR_NBW, default 5, register address width; DATA_NBW, default 32, data width.
REQ-002 SHALL have ports:
- clk  in  1  single clock, rising edge
- rst_async_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage accepts upstream instruction
- i_rs1_addr, i_rs2_addr  in  ADDR_NBW  source register addresses
- i_rd_addr  in  ADDR_NBW  destination address
- i_rd_wr_en  in  1  instruction writes rd
- i_is_load  in  1  instruction is a load
- o_rf_addr_1, o_rf_addr_2  out  ADDR_NBW  register file read addresses
- i_rf_dt_1, i_rf_dt_2  in  DATA_NBW  register file read data (combinational)
- i_exm_wr_en, i_exm_is_load  in  1  EX/MEM producer writes / is load
- i_exm_addr  in  ADDR_NBW;  i_exm_dt  in  DATA_NBW  EX/MEM result
- i_wb_wr_en  in  1;  i_wb_addr  in  ADDR_NBW;  i_wb_dt  in  DATA_NBW  writeback result
- i_flush  in  1  squash held and incoming instruction
- o_valid  out  1  downstream instruction valid
- i_ready  in  1  downstream accepts
- o_rs1_dt, o_rs2_dt  out  DATA_NBW  resolved operands
- o_rd_addr  out  ADDR_NBW;  o_rd_wr_en, o_is_load  out  1  forwarded control

Function
REQ-003 SHALL drive o_rf_addr_1 = i_rs1_addr, o_rf_addr_2 = i_rs2_addr combinationally.
REQ-004 SHALL resolve each operand with priority: address 0 -> 0; EX/MEM match (i_exm_wr_en, addr equal, non-zero, !i_exm_is_load) -> i_exm_dt; WB match (i_wb_wr_en, addr equal, non-zero) -> i_wb_dt; else register file data.
REQ-005 SHALL assert hazard when i_valid and a non-zero rs1/rs2 equals o_rd_addr with o_valid && o_rd_wr_en held (producer result not yet computed).
REQ-006 SHALL assert hazard when i_valid and a non-zero rs1/rs2 equals i_exm_addr with i_exm_wr_en && i_exm_is_load (load-use).
REQ-007 SHALL drive o_ready = (!o_valid || i_ready) && !hazard && !i_flush.
REQ-008 SHALL capture resolved operands and control into the output register when i_valid && o_ready; latency 1 cycle.
REQ-009 SHALL clear o_valid next cycle when downstream accepts (o_valid && i_ready) and no capture occurs (bubble insertion).
REQ-010 SHALL hold all outputs stable while o_valid && !i_ready.
REQ-011 SHALL, on i_flush, clear o_valid next cycle and discard any incoming instruction in that cycle; flush overrides capture and hold.
REQ-012 SHALL keep data outputs unchanged when o_valid clears (only o_valid indicates validity).
REQ-013 SHALL treat simultaneous EX/MEM and WB matches to the same register by selecting EX/MEM.

Reset
REQ-014 SHALL, while rst_async_n low, immediately force o_valid, o_rs1_dt, o_rs2_dt, o_rd_addr, o_rd_wr_en, o_is_load to 0, independent of clk.
REQ-015 SHALL drop any held instruction on reset mid-operation; first capture possible at first rising edge after release.

Verification
REQ-016 Reset: assert rst_async_n low mid-cycle with o_valid=1 -> all outputs 0 immediately, o_ready=1 after release with i_ready=1.
REQ-017 Forwarding: rs1=5, i_exm(addr 5, dt 0xAAAA0000, non-load), i_wb(addr 5, dt 0x1111), rf=0x2222 -> o_rs1_dt=0xAAAA0000 next cycle; rs1=0 with all matching addr 0 -> 0.
REQ-018 Back-to-back RAW: held instr rd=3, incoming rs2=3, i_ready=1 -> o_ready=0 one cycle, bubble (o_valid=0), then capture with i_exm_dt for x3.
REQ-019 Load-use: i_exm load to x7, incoming rs1=7 -> o_ready=0; next cycle i_wb addr 7 dt 0x55 -> captured o_rs1_dt=0x55.
REQ-020 Backpressure/flush: i_ready=0 for 3 cycles -> outputs stable, o_ready=0; then i_flush=1 with i_valid=1 -> o_valid=0 next cycle, instruction not captured.
